// File: rtl/reg_write_queue_pkg.sv
// Shared constants and occupancy-state encoding for reg_write_queue.
package reg_write_queue_pkg;

   localparam int WRQ_WIDTH = 32;
   localparam int WRQ_DEPTH = 4;

   typedef enum logic [1:0] {
      WRQ_ST_EMPTY   = 2'd0,
      WRQ_ST_PARTIAL = 2'd1,
      WRQ_ST_FULL    = 2'd2
   } wrq_state_e;

endpackage

// File: rtl/reg_write_queue_if.sv
// Producer/consumer bus of reg_write_queue.
// Handshake: a value transfers on a rising edge where in_valid && in_ready; in_ready is !full
// from registered state only; out_enable is a one-cycle strobe qualifying out_d; stall blocks pops.
interface reg_write_queue_if
   import reg_write_queue_pkg::*;
#(
   parameter int WIDTH = WRQ_WIDTH,
   parameter int DEPTH = WRQ_DEPTH
) ();

   logic [WIDTH-1:0]       in_data;
   logic                   in_valid;
   logic                   in_ready;
   logic                   stall;
   logic [WIDTH-1:0]       out_d;
   logic                   out_enable;
   logic [$clog2(DEPTH):0] count;
   logic                   empty;
   logic                   full;
   wrq_state_e             state;

   modport master (
      output in_data, in_valid, stall,
      input  in_ready, out_d, out_enable, count, empty, full, state
   );

   modport slave (
      input  in_data, in_valid, stall,
      output in_ready, out_d, out_enable, count, empty, full, state
   );

endinterface

// File: rtl/reg_write_queue_storage.sv
// Queue entry array: one synchronous write port, one asynchronous read port, no reset.
module wrq_storage #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/reg_write_queue.sv
// Write-request FIFO feeding a 32-bit enabled register; drains one value per cycle unless stalled.
// Define WRQ_BYPASS_EN to let a value go straight to the output stage when the queue is empty.
module reg_write_queue
   import reg_write_queue_pkg::*;
#(
   parameter int WIDTH = WRQ_WIDTH,
   parameter int DEPTH = WRQ_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   reg_write_queue_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   wrq_state_e       state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] out_d_q, out_d_d;
   logic             out_en_q, out_en_d;

   logic             empty, full;
   logic             push, pop, bypass, store;
   logic [WIDTH-1:0] rdata;

   assign empty = (state_q == WRQ_ST_EMPTY);
   assign full  = (state_q == WRQ_ST_FULL);

   wrq_storage #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_storage (
      .clk   (clk),
      .we    (store),
      .waddr (wr_ptr_q),
      .wdata (bus.in_data),
      .raddr (rd_ptr_q),
      .rdata (rdata)
   );

   always_comb begin
      push   = bus.in_valid & ~full;
      pop    = ~empty & ~bus.stall;
      bypass = 1'b0;
`ifdef WRQ_BYPASS_EN
      bypass = empty & bus.in_valid & ~bus.stall;
`else
      bypass = 1'b0;
`endif
      // A bypassed value is consumed by the output stage and never occupies an entry.
      store    = push & ~bypass;
      count_d  = count_q + CW'(store) - CW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(store);
      rd_ptr_d = rd_ptr_q + AW'(pop);

      state_d = state_q;
      case (state_q)
         WRQ_ST_EMPTY:   if (store && !pop) state_d = WRQ_ST_PARTIAL;
         WRQ_ST_PARTIAL: begin
            if (count_d == CNT_FULL)  state_d = WRQ_ST_FULL;
            else if (count_d == '0)   state_d = WRQ_ST_EMPTY;
         end
         WRQ_ST_FULL:    if (pop) state_d = WRQ_ST_PARTIAL;
         default:        state_d = WRQ_ST_EMPTY;
      endcase

      out_en_d = 1'b0;
      out_d_d  = out_d_q;
      if (pop) begin
         out_en_d = 1'b1;
         out_d_d  = rdata;
      end else if (bypass) begin
         out_en_d = 1'b1;
         out_d_d  = bus.in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= WRQ_ST_EMPTY;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         out_d_q  <= '0;
         out_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         out_d_q  <= out_d_d;
         out_en_q <= out_en_d;
      end
   end

   assign bus.in_ready   = ~full;
   assign bus.out_d      = out_d_q;
   assign bus.out_enable = out_en_q;
   assign bus.count      = count_q;
   assign bus.empty      = empty;
   assign bus.full       = full;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_reg_write_queue.sv
// Bench for reg_write_queue driving a 32-bit enabled register, checked against a queue model.
module tb_reg_write_queue;

   localparam int W = 32;
   localparam int D = 4;

   logic clk = 1'b0;
   logic reset;
   logic reg_reset;
   logic [W-1:0] reg_q;

   int n_checks = 0;
   int n_errors = 0;

   reg_write_queue_if #(.WIDTH(W), .DEPTH(D)) bus ();

   reg_write_queue #(.WIDTH(W), .DEPTH(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / register under feed ----------------
   always #5 clk = ~clk;

   always_ff @(posedge clk or posedge reg_reset) begin
      if (reg_reset)           reg_q <= '0;
      else if (bus.out_enable) reg_q <= bus.out_d;
   end

   // ---------------- reference model ----------------
   logic [W-1:0] exp_q[$];
   logic         m_en  = 1'b0;
   logic [W-1:0] m_d   = '0;
   logic [W-1:0] m_reg = '0;

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            exp_q.delete();
            m_en = 1'b0;
            m_d  = '0;
            if (reg_reset) m_reg = '0;
         end else begin
            bit do_push, do_pop, byp;
            if (m_en) m_reg = m_d;
            do_push = bus.in_valid && (exp_q.size() < D);
            do_pop  = (exp_q.size() > 0) && !bus.stall;
            byp     = 1'b0;
`ifdef WRQ_BYPASS_EN
            byp = (exp_q.size() == 0) && bus.in_valid && !bus.stall;
`endif
            if (do_pop) begin
               m_d  = exp_q.pop_front();
               m_en = 1'b1;
            end else if (byp) begin
               m_d  = bus.in_data;
               m_en = 1'b1;
            end else begin
               m_en = 1'b0;
            end
            if (do_push && !byp) exp_q.push_back(bus.in_data);
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         chk("out_enable", 32'(bus.out_enable), 32'(m_en));
         chk("out_d", bus.out_d, m_d);
         chk("count", 32'(bus.count), 32'(exp_q.size()));
         chk("empty", 32'(bus.empty), 32'(exp_q.size() == 0));
         chk("full", 32'(bus.full), 32'(exp_q.size() == D));
         chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < D));
         chk("state", 32'(bus.state),
             (exp_q.size() == 0) ? 32'd0 : (exp_q.size() == D) ? 32'd2 : 32'd1);
         chk("reg_q", reg_q, m_reg);
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [W-1:0] v);
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      tick();
      bus.in_valid = 1'b0;
   endtask

   localparam logic [W-1:0] S1 = 32'hA1A1_0001;
   localparam logic [W-1:0] S2 = 32'hA1A1_0002;
   localparam logic [W-1:0] S3 = 32'hA1A1_0003;

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.stall    = 1'b0;
      reset        = 1'b1;
      reg_reset    = 1'b1;
      #10;
      reset     = 1'b0;
      reg_reset = 1'b0;
      #2;
      chk("rst_out_enable", 32'(bus.out_enable), 32'd0);
      chk("rst_out_d", bus.out_d, 32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_reg_q", reg_q, 32'd0);

      // single value, latency
      tick();
      push_one(32'd88);
`ifdef WRQ_BYPASS_EN
      chk("byp_en", 32'(bus.out_enable), 32'd1);
      chk("byp_d", bus.out_d, 32'd88);
      chk("byp_cnt", 32'(bus.count), 32'd0);
      tick();
`else
      chk("lat_cnt1", 32'(bus.count), 32'd1);
      chk("lat_en0", 32'(bus.out_enable), 32'd0);
      tick();
      chk("lat_en1", 32'(bus.out_enable), 32'd1);
      chk("lat_d", bus.out_d, 32'd88);
      chk("lat_cnt0", 32'(bus.count), 32'd0);
      tick();
`endif
      chk("lat_q", reg_q, 32'd88);
      tick();

      // fill while stalled, then offer a fifth value
      bus.stall = 1'b1;
      for (int i = 1; i <= 4; i++) push_one(W'(i));
      chk("fill_full", 32'(bus.full), 32'd1);
      chk("fill_ready", 32'(bus.in_ready), 32'd0);
      chk("fill_cnt", 32'(bus.count), 32'd4);
      push_one(32'd5);
      chk("over_cnt", 32'(bus.count), 32'd4);
      chk("over_full", 32'(bus.full), 32'd1);

      // release stall: q steps 1..4
      bus.stall = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("drain_d", bus.out_d, W'(i));
         chk("drain_en", 32'(bus.out_enable), 32'd1);
         if (i > 1) chk("drain_q", reg_q, W'(i - 1));
      end
      tick();
      chk("drain_q_last", reg_q, 32'd4);
      chk("drain_en_off", 32'(bus.out_enable), 32'd0);

      // continuous streaming
      bus.in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.in_data = $urandom;
         tick();
         chk("stream_cnt_le1", 32'(bus.count <= 1), 32'd1);
         if (i >= 1) chk("stream_en", 32'(bus.out_enable), 32'd1);
      end
      bus.in_valid = 1'b0;
      repeat (4) tick();

      // reset while draining
      bus.stall = 1'b1;
      push_one(S1);
      push_one(S2);
      push_one(S3);
      chk("mid_cnt3", 32'(bus.count), 32'd3);
      bus.stall = 1'b0;
      tick();
      chk("mid_en", 32'(bus.out_enable), 32'd1);
      chk("mid_d", bus.out_d, S1);
      reset = 1'b1;
      #1;
      chk("mid_rst_en", 32'(bus.out_enable), 32'd0);
      chk("mid_rst_cnt", 32'(bus.count), 32'd0);
      chk("mid_rst_empty", 32'(bus.empty), 32'd1);
      #14;
      reset = 1'b0;
      repeat (4) tick();
      chk("no_stale", 32'((reg_q == S1) || (reg_q == S2) || (reg_q == S3)), 32'd0);
      chk("post_cnt", 32'(bus.count), 32'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.stall    = ($urandom_range(0, 3) == 0);
         bus.in_data  = $urandom;
         tick();
      end
      bus.in_valid = 1'b0;
      bus.stall    = 1'b0;
      repeat (8) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
